// File: rtl/hex_display_arbiter.sv
// Round-robin time-multiplexer that hands the six-digit hex display to one
// requester at a time for a fixed dwell, with a hold input that pins the owner.
module hex_display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int OWN_W        = $clog2(NUM_REQ),
  parameter int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                   clk_50,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [24*NUM_REQ-1:0]  req_data,
  input  logic                   hold,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [23:0]            disp_data,
  output logic [OWN_W-1:0]       disp_owner,
  output logic                   disp_valid
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [OWN_W-1:0] OWN_LAST   = OWN_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OWN_W-1:0]   last_owner, last_nxt, owner_nxt;
  logic [23:0]        data_nxt;
  logic               valid_nxt;
  logic [NUM_REQ-1:0] ack_nxt;

  logic               any_valid, own_valid;
  logic [OWN_W-1:0]   win;
  logic [NUM_REQ-1:0] win_oh;
  logic [23:0]        win_data, own_data;
  int                 best_d, d;

  // Priority distance from last_owner+1; last_owner itself is the farthest.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    win_oh    = '0;
    win_data  = '0;
    best_d    = NUM_REQ;
    d         = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + NUM_REQ - 1 - int'(last_owner)) % NUM_REQ;
      if (req_valid[j] && d < best_d) begin
        best_d    = d;
        any_valid = 1'b1;
        win       = OWN_W'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_data  = req_data[24*j +: 24];
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (OWN_W'(j) == disp_owner) begin
        own_valid = req_valid[j];
        own_data  = req_data[24*j +: 24];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_owner;
    owner_nxt = disp_owner;
    data_nxt  = disp_data;
    valid_nxt = disp_valid;
    ack_nxt   = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = SHOW;
          owner_nxt = win;
          last_nxt  = win;
          data_nxt  = win_data;
          valid_nxt = 1'b1;
          ack_nxt   = win_oh;
          cnt_nxt   = CNT_RELOAD;
        end
      end
      SHOW: begin
        if (own_valid) data_nxt = own_data;
        // A frozen counter at 0 defers re-arbitration to the first edge without hold.
        if (!hold) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (!any_valid) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end else begin
            cnt_nxt = CNT_RELOAD;
            if (win != disp_owner) begin
              owner_nxt = win;
              last_nxt  = win;
              data_nxt  = win_data;
              ack_nxt   = win_oh;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWN_LAST;
      disp_owner <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      req_ack    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_nxt;
      disp_owner <= owner_nxt;
      disp_data  <= data_nxt;
      disp_valid <= valid_nxt;
      req_ack    <= ack_nxt;
    end
  end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Time-multiplexes the six-digit hex display between several on-chip requesters (Nios PIO image, status/debug sources). It sits between the requesters and the per-digit `seven_segment_driver` instances. Each requester gets the display for a fixed dwell period, and requesters are served in round-robin order. A `hold` input freezes the current owner, so a board button can pin the display to one source.

## Interface
- `NUM_REQ`, default 4: number of requesters, must be at least 2.
- `DWELL_CYCLES`, default 50_000_000: cycles per grant (1 s at 50 MHz), must be at least 1.
- `OWN_W`, default `$clog2(NUM_REQ)`: width of the owner index.
- `CNT_W`, default `$clog2(DWELL_CYCLES)` (minimum 1): width of the dwell counter.
- `clk_50`  in  1  system clock. The block has one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  level signal: requester i has an image to show.
- `req_data`  in  `24*NUM_REQ`  packed images. Requester i uses `[24*i +: 24]`, nibble k maps to digit k.
- `hold`  in  1  freezes the dwell counter and the current owner. Must be synchronized externally.
- `req_ack`  out  `NUM_REQ`  one-cycle pulse on bit i when requester i is newly granted.
- `disp_data`  out  24  nibble bus to the digit drivers.
- `disp_owner`  out  `OWN_W`  index of the current owner.
- `disp_valid`  out  1  high while a grant is active. The top level blanks the digits when this is low.

## Operation
- There are two states: IDLE and SHOW. There is also a `last_owner` register.
- Arbitration is round-robin. The search starts at `last_owner+1` and wraps modulo `NUM_REQ`. It checks every index, including `last_owner` itself, which is checked last. The first index with `req_valid` high wins.
- In IDLE, if any `req_valid` is high:
  - grant the arbitration winner w;
  - set `disp_owner`=w and `last_owner`=w;
  - load `disp_data` from requester w;
  - set `disp_valid`=1 and pulse `req_ack[w]`;
  - load the counter with `DWELL_CYCLES-1` and go to SHOW.
- `hold` has no effect in IDLE.
- SHOW, every cycle:
  - if `req_valid[owner]` is high, `disp_data` takes `req_data[owner]` (live refresh);
  - otherwise `disp_data` keeps its last value.
- SHOW counter:
  - if `hold` is high, the counter is frozen and nothing else changes apart from the live refresh;
  - if `hold` is low and the counter is not 0, it decrements;
  - if `hold` is low and the counter is 0, re-arbitrate.
- Re-arbitration has three outcomes:
  - A different winner w: switch the owner, load `disp_data` from w, pulse `req_ack[w]`, reload the counter.
  - The only winner is the current owner: keep it, reload the counter, no ack.
  - No `req_valid` high: go to IDLE, set `disp_valid`=0, keep `disp_data` and `disp_owner`.
- `req_ack` is never high on more than one bit, and never for two consecutive cycles on the same bit.
- Reset, whether asserted at any time or mid-SHOW, takes effect immediately:
  - state = IDLE, counter = 0, `last_owner` = `NUM_REQ-1`, so requester 0 has priority after reset;
  - `disp_data`=0, `disp_owner`=0, `disp_valid`=0, `req_ack`=0.

## Timing
- All outputs are registered.
- Grant latency from IDLE: `req_valid` is sampled high at edge k, and the grant outputs take effect after edge k.
- Without `hold`, each grant lasts exactly `DWELL_CYCLES` cycles. The owner change happens at the edge where the counter is 0.
- Switching between owners leaves no gap: `disp_valid` stays high throughout.
- Live refresh has a latency of one cycle from `req_data` to `disp_data`.
- Each cycle of `hold` extends the grant by exactly one cycle.
- `hold` and a counter of 0 on the same edge: the owner stays and the counter stays at 0. Re-arbitration happens on the first edge with `hold` low.
- `req_valid[owner]` dropping mid-dwell does not shorten the grant.

## Test plan
All scenarios use `NUM_REQ`=4 and `DWELL_CYCLES`=4.
- Reset: hold `reset_n` low for 3 cycles, then release with no requests → `disp_valid`=0, `disp_data`=0x000000, `disp_owner`=0, `req_ack`=0 throughout.
- Round-robin:
  - Stimulus: requesters 0 and 2 valid continuously with data 0x111111 and 0x222222.
  - Required grant sequence: owner 0 with ack[0] after the first edge, owner 2 with ack[2] 4 cycles later, owner 0 again 4 cycles after that.
  - `disp_data` alternates between the two images and `disp_valid` never drops.
- Sole requester:
  - Stimulus: only requester 1 valid with data 0x123456, which changes to 0xABCDEF in cycle 6.
  - Required: `req_ack[1]` pulses exactly once and the owner stays 1.
  - `disp_data` shows 0xABCDEF one cycle after the change.
- Hold:
  - Stimulus: requesters 0 and 1 valid, `hold` high for 10 cycles starting in the second cycle of grant 0.
  - Required: the switch to owner 1 happens 14 cycles after the grant, not 4.
- Drain:
  - Stimulus: requester 3 is granted with data 0x00C0DE, then drops `req_valid` in cycle 1 of its dwell.
  - Required: `disp_valid` falls exactly 4 cycles after the grant, and `disp_data` stays 0x00C0DE.
- Reset mid-operation:
  - Stimulus: assert `reset_n` low asynchronously mid-SHOW.
  - Required: outputs clear immediately.
  - After release, requesters 2 and 3 become valid together → owner 0 is not valid, so the winner is 2 with ack[2].
